batcharger_adc_sequencer: RTL and testbench

- Upstream neighbour of the battery-charger controller. Time-multiplexes one shared 8-bit ADC over three channels: battery voltage, battery current and temperature.
- Averages 2^AVG_LOG2 conversions per channel and presents the results as vbat/ibat/tbat.
- Asserts vtok once fresh voltage and temperature data are valid.
- Channel enables come from the controller's imonen/vmonen/tmonen outputs.

---
 rtl/batcharger_adc_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_batcharger_adc_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/batcharger_adc_sequencer.sv
// batcharger_adc_sequencer
//   Time-multiplexes one shared 8-bit ADC over battery voltage (V), current (I)
//   and temperature (T). Each channel is settled, sampled 2^AVG_LOG2 times,
//   averaged and published on vbat/ibat/tbat. vtok reports that fresh V and T
//   results are both valid.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  block enable (0 forces IDLE, discards partial data)
//   vmonen/imonen/tmonen channel enables from the charger controller
//   adc_sel             mux select 00=V 01=I 10=T
//   adc_start           one-cycle conversion request
//   adc_done, adc_data  conversion-complete strobe and its result
//   vbat/ibat/tbat      averaged channel codes
//   vtok                V and T values valid
//   adc_err             sticky conversion timeout flag
module batcharger_adc_sequencer #(
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       vmonen,
  input  logic       imonen,
  input  logic       tmonen,
  output logic [1:0] adc_sel,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [7:0] vbat,
  output logic [7:0] ibat,
  output logic [7:0] tbat,
  output logic       vtok,
  output logic       adc_err
);

  localparam int unsigned ACC_W = 8 + AVG_LOG2;
  localparam int unsigned NSAMP = 1 << AVG_LOG2;

  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, UPDATE} state_t;
  typedef enum logic [1:0] {CH_V = 2'b00, CH_I = 2'b01, CH_T = 2'b10} chan_t;

  state_t           state;
  chan_t            ch;
  logic [7:0]       settle_cnt;
  logic [4:0]       cnt;
  logic [ACC_W-1:0] acc;
  logic [9:0]       tmo;
  logic             v_ok;
  logic             t_ok;

  logic [2:0]       en_vec;
  logic             any_en;
  chan_t            first_ch;
  chan_t            c1;
  chan_t            c2;
  chan_t            next_ch;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       avg;
  logic             tmo_fire;
  logic             flag_clr;

  assign adc_sel = ch;

  always_comb begin
    en_vec   = {tmonen, imonen, vmonen};
    any_en   = |en_vec;
    first_ch = CH_V;
    if (vmonen)      first_ch = CH_V;
    else if (imonen) first_ch = CH_I;
    else if (tmonen) first_ch = CH_T;

    // Cyclic search starting after the current channel; the current channel
    // is checked last so next_ch == ch means it is the only one enabled.
    c1 = CH_I;
    c2 = CH_T;
    unique case (ch)
      CH_V:    begin c1 = CH_I; c2 = CH_T; end
      CH_I:    begin c1 = CH_T; c2 = CH_V; end
      default: begin c1 = CH_V; c2 = CH_I; end
    endcase
    if (en_vec[c1])      next_ch = c1;
    else if (en_vec[c2]) next_ch = c2;
    else                 next_ch = ch;

    acc_sum = acc + ACC_W'(adc_data);
    avg     = 8'(acc >> AVG_LOG2);

    // Timeout is declared in the cycle where the counter would step onto
    // TIMEOUT_CYC; an adc_done in that same cycle takes precedence.
    tmo_fire = (state == CONVERT) && !adc_start && !adc_done &&
               (tmo == 10'(TIMEOUT_CYC - 1));
    flag_clr = !en || !vmonen || !tmonen || tmo_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= CH_V;
      adc_start  <= 1'b0;
      settle_cnt <= '0;
      cnt        <= '0;
      acc        <= '0;
      tmo        <= '0;
      vbat       <= '0;
      ibat       <= '0;
      tbat       <= '0;
      vtok       <= 1'b0;
      v_ok       <= 1'b0;
      t_ok       <= 1'b0;
      adc_err    <= 1'b0;
    end else begin
      if (flag_clr) begin
        v_ok <= 1'b0;
        t_ok <= 1'b0;
        vtok <= 1'b0;
      end else begin
        vtok <= v_ok & t_ok;
        if (state == UPDATE && ch == CH_V) v_ok <= 1'b1;
        if (state == UPDATE && ch == CH_T) t_ok <= 1'b1;
      end

      if (!en) begin
        state     <= IDLE;
        adc_start <= 1'b0;
        adc_err   <= 1'b0;
        acc       <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            adc_start <= 1'b0;
            if (any_en) begin
              ch         <= first_ch;
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_cnt == 8'(SETTLE_CYC - 1)) begin
              state     <= CONVERT;
              adc_start <= 1'b1;
              cnt       <= '0;
              acc       <= '0;
              tmo       <= '0;
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
          CONVERT: begin
            if (adc_start) begin
              adc_start <= 1'b0;
              tmo       <= 10'd1;
            end else if (adc_done) begin
              acc <= acc_sum;
              if (cnt == 5'(NSAMP - 1)) begin
                state <= UPDATE;
              end else begin
                cnt       <= cnt + 5'd1;
                adc_start <= 1'b1;
                tmo       <= '0;
              end
            end else if (tmo_fire) begin
              adc_err <= 1'b1;
              acc     <= '0;
              if (any_en) begin
                ch         <= first_ch;
                settle_cnt <= '0;
                state      <= SETTLE;
              end else begin
                state <= IDLE;
              end
            end else begin
              tmo <= tmo + 10'd1;
            end
          end
          UPDATE: begin
            unique case (ch)
              CH_V:    vbat <= avg;
              CH_I:    ibat <= avg;
              default: tbat <= avg;
            endcase
            if (!any_en) begin
              state <= IDLE;
            end else if (next_ch == ch) begin
              state     <= CONVERT;
              adc_start <= 1'b1;
              cnt       <= '0;
              acc       <= '0;
              tmo       <= '0;
            end else begin
              ch         <= next_ch;
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_batcharger_adc_sequencer.sv
// Directed/randomized bench for batcharger_adc_sequencer with a behavioural
// ADC responder and a channel-level reference model.
module tb_batcharger_adc_sequencer;

  localparam int AVG_LOG2    = 2;
  localparam int SETTLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int NS          = 4;

  logic       clk = 1'b0;
  logic       rst, en, vmonen, imonen, tmonen, adc_done;
  logic [7:0] adc_data;
  logic [1:0] adc_sel;
  logic       adc_start, vtok, adc_err;
  logic [7:0] vbat, ibat, tbat;

  batcharger_adc_sequencer #(
    .AVG_LOG2(AVG_LOG2),
    .SETTLE_CYC(SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .vmonen(vmonen), .imonen(imonen), .tmonen(tmonen),
    .adc_sel(adc_sel), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data),
    .vbat(vbat), .ibat(ibat), .tbat(tbat),
    .vtok(vtok), .adc_err(adc_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int start_cnt = 0, sel_i_cnt = 0, sel_t_cnt = 0, sel_bad_cnt = 0;
  always @(posedge clk) begin
    if (adc_start === 1'b1) start_cnt <= start_cnt + 1;
    if (adc_sel === 2'b01)  sel_i_cnt <= sel_i_cnt + 1;
    if (adc_sel === 2'b10)  sel_t_cnt <= sel_t_cnt + 1;
    if (adc_sel === 2'b11)  sel_bad_cnt <= sel_bad_cnt + 1;
  end

  // Reference model: per-channel published values and V/T freshness.
  int m_out[3];
  bit m_vok, m_tok;
  int cur_ch;
  int exp_wait;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit ch_en(input int c);
    return (c == 0) ? vmonen : (c == 1) ? imonen : tmonen;
  endfunction

  function automatic int first_en();
    for (int c = 0; c < 3; c++) if (ch_en(c)) return c;
    return -1;
  endfunction

  function automatic int model_next(input int c);
    for (int k = 1; k <= 3; k++) if (ch_en((c + k) % 3)) return (c + k) % 3;
    return -1;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_vbat"}, vbat, m_out[0]);
    check({tag, "_ibat"}, ibat, m_out[1]);
    check({tag, "_tbat"}, tbat, m_out[2]);
  endtask

  // Wait for a start on channel ch, answer lat cycles later with data.
  task automatic do_conv(input int ch, input logic [7:0] data, input int lat, input int expw);
    int waited;
    waited = 0;
    while (adc_start !== 1'b1 && waited < 300) begin
      tick;
      waited++;
    end
    check("start_seen", adc_start, 1);
    if (expw >= 0) check("start_wait", waited, expw);
    check("adc_sel", adc_sel, ch);
    tick;
    check("start_pulse", adc_start, 0);
    repeat (lat - 1) tick;
    adc_done = 1'b1;
    adc_data = data;
    tick;
    adc_done = 1'b0;
    adc_data = 8'($urandom);
  endtask

  // One full averaging burst on the model's current channel.
  task automatic burst(input int base, input int step, input int lat);
    int sum, ch, d, l, nxt;
    sum = 0;
    ch  = cur_ch;
    for (int i = 0; i < NS; i++) begin
      d = (base < 0) ? int'($urandom_range(0, 255)) : base + i * step;
      l = (lat > 0) ? lat : int'($urandom_range(1, 20));
      sum += d;
      do_conv(ch, d[7:0], l, (i == 0) ? exp_wait : 0);
    end
    tick;
    m_out[ch] = sum / NS;
    check_outputs("update");
    check("vtok_hold", vtok, m_vok && m_tok);
    if (en && vmonen && tmonen) begin
      if (ch == 0) m_vok = 1'b1;
      if (ch == 2) m_tok = 1'b1;
    end
    nxt = model_next(ch);
    if (nxt == ch) begin
      exp_wait = 0;
    end else begin
      tick;
      check("vtok", vtok, m_vok && m_tok);
      exp_wait = SETTLE_CYC - 1;
    end
    cur_ch = nxt;
  endtask

  initial begin
    int s0, si, st, sc, k, waited;

    rst = 1'b1; en = 1'b0; vmonen = 1'b0; imonen = 1'b0; tmonen = 1'b0;
    adc_done = 1'b0; adc_data = 8'd0;
    m_out = '{0, 0, 0}; m_vok = 0; m_tok = 0;
    repeat (3) tick;
    check_outputs("reset");
    check("reset_vtok", vtok, 0);
    check("reset_err", adc_err, 0);
    check("reset_start", adc_start, 0);
    check("reset_sel", adc_sel, 0);
    rst = 1'b0;

    // Voltage only: fixed samples 100..103, single-channel loop.
    en = 1'b1; vmonen = 1'b1;
    tick;
    cur_ch = first_en(); exp_wait = SETTLE_CYC;
    s0 = start_cnt; si = sel_i_cnt; st = sel_t_cnt;
    burst(100, 1, 10);
    check("vbat_avg", vbat, 101);
    check("v_only_starts", start_cnt - s0, 4);
    burst(-1, 0, 0);
    check("v_only_vtok", vtok, 0);
    check("v_only_sel_i", sel_i_cnt - si, 0);
    check("v_only_sel_t", sel_t_cnt - st, 0);

    // All channels: constant round then random round.
    imonen = 1'b1; tmonen = 1'b1;
    burst(200, 0, 10);
    burst(50, 0, 10);
    burst(120, 0, 10);
    check("vtok_round1", vtok, 1);
    burst(-1, 0, 0);
    burst(-1, 0, 0);

    // en drops mid-conversion on T.
    do_conv(cur_ch, 8'($urandom), 5, exp_wait);
    check("t_second_start", adc_start, 1);
    tick; tick;
    check("vtok_before_drop", vtok, 1);
    en = 1'b0;
    sc = start_cnt;
    tick;
    check("drop_vtok", vtok, 0);
    check("drop_start", adc_start, 0);
    m_vok = 0; m_tok = 0;
    adc_done = 1'b1; adc_data = 8'($urandom);
    tick;
    adc_done = 1'b0;
    repeat (3) tick;
    check_outputs("drop_hold");
    check("drop_no_start", start_cnt - sc, 0);
    en = 1'b1;
    tick;
    cur_ch = first_en(); exp_wait = SETTLE_CYC;

    // Timeout on V after a full round, then recovery.
    burst(-1, 0, 0);
    burst(-1, 0, 0);
    burst(-1, 0, 0);
    waited = 0;
    while (adc_start !== 1'b1 && waited < 300) begin tick; waited++; end
    check("to_start_wait", waited, exp_wait);
    check("to_sel", adc_sel, 0);
    k = 0;
    while (adc_err !== 1'b1 && k < 300) begin tick; k++; end
    check("timeout_cycles", k, TIMEOUT_CYC);
    check("timeout_vtok", vtok, 0);
    check("timeout_sel", adc_sel, 0);
    check_outputs("timeout_hold");
    m_vok = 0; m_tok = 0;
    cur_ch = 0; exp_wait = SETTLE_CYC;
    burst(-1, 0, 0);
    burst(-1, 0, 0);
    burst(-1, 0, 0);
    check("recover_vtok", vtok, 1);
    check("recover_err_sticky", adc_err, 1);

    // Reset mid-averaging.
    do_conv(cur_ch, 8'($urandom), 5, exp_wait);
    tick;
    rst = 1'b1;
    tick;
    m_out = '{0, 0, 0}; m_vok = 0; m_tok = 0;
    check_outputs("midrst");
    check("midrst_vtok", vtok, 0);
    check("midrst_err", adc_err, 0);
    check("midrst_start", adc_start, 0);
    check("midrst_sel", adc_sel, 0);
    rst = 1'b0; imonen = 1'b0;
    tick;
    cur_ch = first_en(); exp_wait = SETTLE_CYC;
    si = sel_i_cnt;

    // V and T only; first burst answers in the last legal cycle.
    burst(-1, 0, TIMEOUT_CYC - 1);
    check("edge_done_err", adc_err, 0);
    burst(-1, 0, 0);
    burst(-1, 0, 0);
    burst(-1, 0, 0);
    check("vt_vtok", vtok, 1);
    check("vt_no_sel_i", sel_i_cnt - si, 0);
    check("vt_ibat", ibat, 0);
    check("never_sel_11", sel_bad_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
